// File: rtl/mem_bus_master_if.sv
// Core-side request/response and memory-side control signals of the data memory master.
// The shared 32-bit data bus stays a plain inout on the master so the tristate resolves at top level.
interface mem_bus_master_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic              byte_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [1:0]        mem_write;

  modport master (
    input  req, we, byte_en, addr, wdata,
    output rdata, busy, done, mem_addr, mem_read, mem_write
  );

  modport slave (
    output req, we, byte_en, addr, wdata,
    input  rdata, busy, done, mem_addr, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the shared data memory bus: one load/store per req, controls held
// WAIT_CYCLES clocks, then a one-cycle done pulse that doubles as the bus turnaround cycle.
module mem_bus_master #(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 12
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_master_if.master   ctrl,
  inout  wire  [31:0]        BUS
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              byteEn_q, byteEn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              memRead_q, memRead_d;
  logic [1:0]        memWrite_q, memWrite_d;
  logic              drvEn_q, drvEn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      byteEn_q   <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      memAddr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 2'b00;
      drvEn_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      byteEn_q   <= byteEn_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      memAddr_q  <= memAddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      drvEn_q    <= drvEn_d;
    end
  end

  // Request latch, dwell counter and load capture on the last ACCESS edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    byteEn_d = byteEn_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl.req) begin
          addr_d   = ctrl.addr;
          we_d     = ctrl.we;
          byteEn_d = ctrl.byte_en;
          wdata_d  = ctrl.wdata;
          cnt_d    = CNT_LOAD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          if (!we_q) rdata_d = BUS;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change exactly on state edges.
  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    memRead_d  = 1'b0;
    memWrite_d = 2'b00;
    drvEn_d    = 1'b0;
    memAddr_d  = memAddr_q;
    if (state_d == ACCESS) begin
      memAddr_d  = addr_d;
      memRead_d  = !we_d;
      drvEn_d    = we_d;
      memWrite_d = we_d ? (byteEn_d ? 2'b11 : 2'b01) : 2'b00;
    end
  end

  assign BUS            = drvEn_q ? wdata_q : 32'hzzzz_zzzz;
  assign ctrl.rdata     = rdata_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.mem_addr  = memAddr_q;
  assign ctrl.mem_read  = memRead_q;
  assign ctrl.mem_write = memWrite_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: byte-array memory on a pulled-up bus, plus a
// byte-level reference memory that predicts load results from the requests issued.
module tb_mem_bus_master;

  localparam int W  = 4;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_master_if #(.ADDR_W(AW)) ifc ();
  wire [31:0] tbBus;
  pullup (tbBus);

  mem_bus_master #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc),
    .BUS  (tbBus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int doneCycles[$];

  logic [7:0]  envMem [0:4095];
  logic [7:0]  refMem [0:4095];
  logic [31:0] envRead;

  // Memory environment: little-endian bytes, drives the bus only while mem_read is high.
  assign envRead = {envMem[ifc.mem_addr + 12'd3], envMem[ifc.mem_addr + 12'd2],
                    envMem[ifc.mem_addr + 12'd1], envMem[ifc.mem_addr]};
  assign tbBus = ifc.mem_read ? envRead : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.mem_write == 2'b01)
      for (int i = 0; i < 4; i++) envMem[12'(ifc.mem_addr + 12'(i))] <= tbBus[8*i +: 8];
    else if (ifc.mem_write == 2'b11)
      envMem[ifc.mem_addr] <= tbBus[7:0];
  end

  // Bus-contention watch: no write code and no foreign driver while the memory drives.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.done) doneCycles.push_back(cyc);
      if (ifc.mem_read) begin
        vectors++;
        if (ifc.mem_write !== 2'b00 || tbBus !== envRead) begin
          miscompares++;
          $display("[TB] FAIL contention: mem_write=%b bus=%h memory=%h", ifc.mem_write, tbBus, envRead);
        end
      end
    end
  end

  function automatic logic [31:0] refWord(input logic [AW-1:0] a);
    return {refMem[12'(a + 12'd3)], refMem[12'(a + 12'd2)], refMem[12'(a + 12'd1)], refMem[a]};
  endfunction

  function automatic void refStore(input logic b, input logic [AW-1:0] a, input logic [31:0] d);
    if (b) refMem[a] = d[7:0];
    else for (int i = 0; i < 4; i++) refMem[12'(a + 12'(i))] = d[8*i +: 8];
  endfunction

  // Runs one access starting from a negedge in IDLE and ends on the negedge of the following IDLE cycle.
  task automatic doAccess(input logic w, input logic b, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic hold, output int ctrlCnt, output int badCnt, output int doneAt,
                          output logic busRel, output logic [31:0] rd, output logic idleOk);
    logic [31:0] expBus;
    logic [1:0]  expMw;
    expBus = w ? d : refWord(a);
    expMw  = w ? (b ? 2'b11 : 2'b01) : 2'b00;
    ifc.req = 1'b1; ifc.we = w; ifc.byte_en = b; ifc.addr = a; ifc.wdata = d;
    @(posedge clk); #1;
    ifc.req = hold; ifc.we = 1'($urandom); ifc.byte_en = 1'($urandom);
    ifc.addr = AW'($urandom); ifc.wdata = $urandom;
    ctrlCnt = 0; badCnt = 0; doneAt = 0; busRel = 1'b0; rd = '0; idleOk = 1'b0;
    for (int k = 1; k <= W + 4 && doneAt == 0; k++) begin
      @(negedge clk);
      if (ifc.mem_read || ifc.mem_write != 2'b00) ctrlCnt++;
      if (k <= W && (ifc.mem_addr !== a || ifc.mem_read !== !w || ifc.mem_write !== expMw ||
                     tbBus !== expBus || ifc.busy !== 1'b1 || ifc.done !== 1'b0)) badCnt++;
      if (ifc.done === 1'b1) begin
        doneAt = k;
        busRel = (tbBus === 32'hFFFF_FFFF) && (ifc.mem_read === 1'b0) &&
                 (ifc.mem_write === 2'b00) && (ifc.busy === 1'b1);
        rd = ifc.rdata;
      end
    end
    @(negedge clk);
    idleOk = (ifc.busy === 1'b0) && (ifc.done === 1'b0) && (ifc.mem_read === 1'b0) &&
             (ifc.mem_write === 2'b00) && (tbBus === 32'hFFFF_FFFF);
    if (w) refStore(b, a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b want=0", ifc.busy); end
    vectors++; if (ifc.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got=%b want=0", ifc.done); end
    vectors++; if (ifc.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_read got=%b want=0", ifc.mem_read); end
    vectors++; if (ifc.mem_write !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_mem_write got=%b want=00", ifc.mem_write); end
    vectors++; if (tbBus !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL reset_bus_released got=%h want=ffffffff", tbBus); end
    vectors++; if (ifc.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata got=%h want=0", ifc.rdata); end
    vectors++; if (ifc.mem_addr !== 12'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got=%h want=0", ifc.mem_addr); end
  endtask

  task automatic test_word_store_load();
    int cc, bc, da; logic br, io; logic [31:0] rd;
    doAccess(1'b1, 1'b0, 12'h010, 32'hDEAD_BEEF, 1'b0, cc, bc, da, br, rd, io);
    vectors++; if (cc != W) begin miscompares++; $display("[TB] FAIL store_ctrl_len got=%0d want=%0d", cc, W); end
    vectors++; if (bc != 0) begin miscompares++; $display("[TB] FAIL store_ctrl_values bad_cycles=%0d want=0", bc); end
    vectors++; if (da != W + 1) begin miscompares++; $display("[TB] FAIL store_done_cycle got=%0d want=%0d", da, W + 1); end
    vectors++; if (br !== 1'b1) begin miscompares++; $display("[TB] FAIL store_done_bus_released got=%b want=1", br); end
    vectors++; if (io !== 1'b1) begin miscompares++; $display("[TB] FAIL store_idle_after got=%b want=1", io); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL store_keeps_rdata got=%h want=0", rd); end
    doAccess(1'b0, 1'b1, 12'h010, 32'h0, 1'b0, cc, bc, da, br, rd, io);
    vectors++; if (cc != W) begin miscompares++; $display("[TB] FAIL load_ctrl_len got=%0d want=%0d", cc, W); end
    vectors++; if (bc != 0) begin miscompares++; $display("[TB] FAIL load_ctrl_values bad_cycles=%0d want=0", bc); end
    vectors++; if (da != W + 1) begin miscompares++; $display("[TB] FAIL load_done_cycle got=%0d want=%0d", da, W + 1); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL load_rdata got=%h want=deadbeef", rd); end
    vectors++; if (ifc.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL load_rdata_hold got=%h want=deadbeef", ifc.rdata); end
  endtask

  task automatic test_byte_store();
    int cc, bc, da; logic br, io; logic [31:0] rd;
    doAccess(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, cc, bc, da, br, rd, io);
    doAccess(1'b1, 1'b1, 12'h011, 32'h1234_56A5, 1'b0, cc, bc, da, br, rd, io);
    vectors++; if (bc != 0) begin miscompares++; $display("[TB] FAIL byte_store_ctrl bad_cycles=%0d want=0", bc); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL byte_store_keeps_rdata got=%h want=deadbeef", rd); end
    doAccess(1'b0, 1'b0, 12'h010, 32'h0, 1'b0, cc, bc, da, br, rd, io);
    vectors++; if (rd !== 32'h0000_A500) begin miscompares++; $display("[TB] FAIL byte_load_rdata got=%h want=0000a500", rd); end
  endtask

  task automatic test_random();
    int cc, bc, da; logic br, io; logic [31:0] rd, exp;
    logic w, b; logic [AW-1:0] a;
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom);
      b = 1'($urandom);
      a = (n % 6 == 0) ? 12'hFFE + 12'(n % 2) : AW'($urandom);
      exp = w ? rd : refWord(a);
      if (w) exp = ifc.rdata;
      doAccess(w, b, a, $urandom, 1'b0, cc, bc, da, br, rd, io);
      vectors++;
      if (bc != 0 || da != W + 1 || br !== 1'b1 || io !== 1'b1 || rd !== exp) begin
        miscompares++;
        $display("[TB] FAIL random_%0d we=%b addr=%h rdata=%h want=%h bad=%0d done_at=%0d rel=%b idle=%b",
                 n, w, a, rd, exp, bc, da, br, io);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cc, bc, da; logic br, io; logic [31:0] rd, d;
    logic [AW-1:0] a;
    doneCycles.delete();
    for (int n = 0; n < 6; n++) begin
      a = AW'($urandom);
      d = $urandom;
      doAccess(1'b1, 1'b0, a, d, 1'b1, cc, bc, da, br, rd, io);
      vectors++; if (bc != 0 || io !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_store_%0d bad=%0d idle=%b", n, bc, io); end
      doAccess(1'b0, 1'b0, a, 32'h0, 1'b1, cc, bc, da, br, rd, io);
      vectors++; if (bc != 0 || rd !== d) begin miscompares++; $display("[TB] FAIL b2b_load_%0d rdata=%h want=%h bad=%0d", n, rd, d, bc); end
    end
    ifc.req = 1'b0;
    vectors++; if (doneCycles.size() != 12) begin miscompares++; $display("[TB] FAIL b2b_done_count got=%0d want=12", doneCycles.size()); end
    for (int i = 1; i < doneCycles.size(); i++) begin
      vectors++;
      if (doneCycles[i] - doneCycles[i-1] != W + 2) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing_%0d got=%0d want=%0d", i, doneCycles[i] - doneCycles[i-1], W + 2);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cc, bc, da; logic br, io; logic [31:0] rd;
    int doneSeen;
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.byte_en = 1'b0; ifc.addr = 12'h200; ifc.wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    ifc.req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    vectors++; if (tbBus !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL midrst_bus got=%h want=ffffffff", tbBus); end
    vectors++; if (ifc.mem_write !== 2'b00) begin miscompares++; $display("[TB] FAIL midrst_mem_write got=%b want=00", ifc.mem_write); end
    vectors++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy_done got=%b%b want=00", ifc.busy, ifc.done); end
    @(negedge clk);
    rst = 1'b0;
    refStore(1'b0, 12'h200, 32'h0BAD_F00D);
    doneSeen = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) doneSeen++;
    end
    vectors++; if (doneSeen != 0) begin miscompares++; $display("[TB] FAIL midrst_no_done got=%0d pulses want=0", doneSeen); end
    doAccess(1'b1, 1'b0, 12'h300, 32'h5566_7788, 1'b0, cc, bc, da, br, rd, io);
    doAccess(1'b0, 1'b0, 12'h300, 32'h0, 1'b0, cc, bc, da, br, rd, io);
    vectors++; if (rd !== 32'h5566_7788 || da != W + 1) begin miscompares++; $display("[TB] FAIL midrst_recover rdata=%h want=55667788 done_at=%0d", rd, da); end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin envMem[i] = 8'h00; refMem[i] = 8'h00; end
    ifc.req = 1'b0; ifc.we = 1'b0; ifc.byte_en = 1'b0; ifc.addr = '0; ifc.wdata = '0;
    @(negedge clk);
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
